// File: rtl/pad_report_sched.sv
// Gamepad report sequencer: owns the UART transmitter, sends periodic 6-byte
// report packets and answers single-byte host commands (report now, ping).
module pad_report_sched #(
   parameter logic [23:0] REPORT_PERIOD = 24'd500000,
   parameter logic [7:0]  SYNC_BYTE     = 8'hA5,
   parameter logic [7:0]  PING_REPLY    = 8'h5A,
   parameter logic [7:0]  CMD_REPORT    = 8'h01,
   parameter logic [7:0]  CMD_PING      = 8'h02
) (
   input  logic        iCLK,
   input  logic        iRESET,
   input  logic        iENABLE,
   input  logic [15:0] iBUTTONS,
   input  logic [7:0]  iAXIS_X,
   input  logic [7:0]  iAXIS_Y,
   input  logic        iREC_END,
   input  logic [7:0]  iRX_BYTE,
   input  logic        iREC_ER,
   input  logic        iTRAN_BUSY,
   output logic        oTRAN_ST,
   output logic [7:0]  oTX_BYTE,
   output logic        oPKT_BUSY,
   output logic [7:0]  oPKT_CNT,
   output logic [7:0]  oERR_CNT
);

   typedef enum logic [2:0] {IDLE, LOAD, STROBE, WAIT_ACK, WAIT_DONE} state_t;

   state_t      state_q;
   logic [23:0] periodCnt_q, periodCnt_d;
   logic        tick;
   logic        rptPend_q, pingPend_q;
   logic        cmdValid, rptSet, pingSet, errInc;
   logic [7:0]  errCnt_q, errCnt_d;
   logic [7:0]  pktCnt_q;
   logic [7:0]  txByte_q;
   logic        tranSt_q;
   logic [7:0]  pktBuf_q [6];
   logic [2:0]  len_q, idx_q, idxNext;
   logic        isRpt_q;
   logic [1:0]  ackCnt_q;
   logic        grantPing, grantRpt;

   always_comb begin
      tick        = 1'b0;
      periodCnt_d = periodCnt_q;
      if (!iENABLE) begin
         periodCnt_d = '0;
      end else if (periodCnt_q == REPORT_PERIOD - 24'd1) begin
         periodCnt_d = '0;
         tick        = 1'b1;
      end else begin
         periodCnt_d = periodCnt_q + 24'd1;
      end
   end

   // A framing error takes precedence over whatever byte arrived with it.
   always_comb begin
      cmdValid = iREC_END && !iREC_ER;
      rptSet   = tick || (cmdValid && iRX_BYTE == CMD_REPORT);
      pingSet  = cmdValid && iRX_BYTE == CMD_PING;
      errInc   = iREC_ER ||
                 (cmdValid && iRX_BYTE != CMD_REPORT && iRX_BYTE != CMD_PING);
      errCnt_d = (errInc && errCnt_q != 8'hFF) ? errCnt_q + 8'd1 : errCnt_q;
   end

   assign grantPing = (state_q == IDLE) && pingPend_q;
   assign grantRpt  = (state_q == IDLE) && !pingPend_q && rptPend_q;
   assign idxNext   = idx_q + 3'd1;

   always_ff @(posedge iCLK) begin
      if (!iRESET) begin
         state_q     <= IDLE;
         periodCnt_q <= '0;
         rptPend_q   <= 1'b0;
         pingPend_q  <= 1'b0;
         errCnt_q    <= '0;
         pktCnt_q    <= '0;
         txByte_q    <= '0;
         tranSt_q    <= 1'b0;
         len_q       <= '0;
         idx_q       <= '0;
         isRpt_q     <= 1'b0;
         ackCnt_q    <= '0;
         for (int i = 0; i < 6; i++) pktBuf_q[i] <= '0;
      end else begin
         periodCnt_q <= periodCnt_d;
         errCnt_q    <= errCnt_d;
         // A request landing in the grant cycle survives and is serviced again.
         rptPend_q   <= rptSet || (rptPend_q && !grantRpt);
         pingPend_q  <= pingSet || (pingPend_q && !grantPing);
         tranSt_q    <= 1'b0;
         case (state_q)
            IDLE: begin
               if (grantPing) begin
                  isRpt_q <= 1'b0;
                  state_q <= LOAD;
               end else if (grantRpt) begin
                  isRpt_q <= 1'b1;
                  state_q <= LOAD;
               end
            end
            LOAD: begin
               idx_q <= '0;
               if (isRpt_q) begin
                  pktBuf_q[0] <= SYNC_BYTE;
                  pktBuf_q[1] <= iBUTTONS[7:0];
                  pktBuf_q[2] <= iBUTTONS[15:8];
                  pktBuf_q[3] <= iAXIS_X;
                  pktBuf_q[4] <= iAXIS_Y;
                  pktBuf_q[5] <= iBUTTONS[7:0] ^ iBUTTONS[15:8] ^ iAXIS_X ^ iAXIS_Y;
                  len_q       <= 3'd6;
               end else begin
                  pktBuf_q[0] <= PING_REPLY;
                  len_q       <= 3'd1;
               end
               state_q <= STROBE;
            end
            STROBE: begin
               if (!iTRAN_BUSY) begin
                  txByte_q <= pktBuf_q[idx_q];
                  tranSt_q <= 1'b1;
                  ackCnt_q <= '0;
                  state_q  <= WAIT_ACK;
               end
            end
            // No busy within four cycles means the strobe was missed; resend it.
            WAIT_ACK: begin
               if (iTRAN_BUSY) begin
                  state_q <= WAIT_DONE;
               end else if (ackCnt_q == 2'd3) begin
                  state_q <= STROBE;
               end else begin
                  ackCnt_q <= ackCnt_q + 2'd1;
               end
            end
            WAIT_DONE: begin
               if (!iTRAN_BUSY) begin
                  idx_q <= idxNext;
                  if (idxNext == len_q) begin
                     state_q <= IDLE;
                     if (isRpt_q) pktCnt_q <= pktCnt_q + 8'd1;
                  end else begin
                     state_q <= STROBE;
                  end
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign oTRAN_ST  = tranSt_q;
   assign oTX_BYTE  = txByte_q;
   assign oPKT_BUSY = (state_q != IDLE);
   assign oPKT_CNT  = pktCnt_q;
   assign oERR_CNT  = errCnt_q;

endmodule

// File: tb/tb_pad_report_sched.sv
// Scoreboard bench for pad_report_sched: a UART model accepts strobes and
// every accepted byte is compared against the queue of expected bytes.
module tb_pad_report_sched;

   logic        iCLK = 1'b0;
   logic        iRESET = 1'b0;
   logic        iENABLE = 1'b0;
   logic [15:0] iBUTTONS = '0;
   logic [7:0]  iAXIS_X = '0;
   logic [7:0]  iAXIS_Y = '0;
   logic        iREC_END = 1'b0;
   logic [7:0]  iRX_BYTE = '0;
   logic        iREC_ER = 1'b0;
   logic        iTRAN_BUSY = 1'b0;
   logic        oTRAN_ST;
   logic [7:0]  oTX_BYTE;
   logic        oPKT_BUSY;
   logic [7:0]  oPKT_CNT;
   logic [7:0]  oERR_CNT;

   int          errors = 0;
   int          checks = 0;
   int          cycle = 0;
   int          busyCnt = 0;
   int          dropLeft = 0;
   logic [7:0]  dropByte = '0;
   int          dropCyc = 0;
   logic [7:0]  expQ [$];
   int          logCyc [$];

   pad_report_sched #(.REPORT_PERIOD(24'd1000)) dut (
      .iCLK(iCLK), .iRESET(iRESET), .iENABLE(iENABLE), .iBUTTONS(iBUTTONS),
      .iAXIS_X(iAXIS_X), .iAXIS_Y(iAXIS_Y), .iREC_END(iREC_END),
      .iRX_BYTE(iRX_BYTE), .iREC_ER(iREC_ER), .iTRAN_BUSY(iTRAN_BUSY),
      .oTRAN_ST(oTRAN_ST), .oTX_BYTE(oTX_BYTE), .oPKT_BUSY(oPKT_BUSY),
      .oPKT_CNT(oPKT_CNT), .oERR_CNT(oERR_CNT)
   );

   always #5 iCLK = ~iCLK;

   always @(posedge iCLK) cycle++;

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // UART model: each accepted strobe holds busy for 20 cycles; dropLeft
   // strobes are ignored entirely to exercise the re-strobe path.
   always @(negedge iCLK) begin
      if (oTRAN_ST) begin
         if (dropLeft > 0) begin
            dropLeft--;
            dropByte = oTX_BYTE;
            dropCyc  = cycle;
         end else begin
            busyCnt    = 20;
            iTRAN_BUSY = 1'b1;
            logCyc.push_back(cycle);
            if (expQ.size() == 0) checkOutput("txExtra", 32'(expQ.size()), 32'd1);
            else checkOutput("txByte", {24'd0, oTX_BYTE}, {24'd0, expQ.pop_front()});
         end
      end else if (busyCnt > 0) begin
         busyCnt--;
         if (busyCnt == 0) iTRAN_BUSY = 1'b0;
      end
   end

   task automatic pushReport(input logic [15:0] b, input logic [7:0] x, input logic [7:0] y);
      expQ.push_back(8'hA5);
      expQ.push_back(b[7:0]);
      expQ.push_back(b[15:8]);
      expQ.push_back(x);
      expQ.push_back(y);
      expQ.push_back(b[7:0] ^ b[15:8] ^ x ^ y);
   endtask

   task automatic applyStimulus(input logic isErr, input logic [7:0] b);
      @(negedge iCLK);
      iRX_BYTE = b;
      iREC_END = !isErr;
      iREC_ER  = isErr;
      @(negedge iCLK);
      iREC_END = 1'b0;
      iREC_ER  = 1'b0;
   endtask

   task automatic doReset();
      @(negedge iCLK);
      iRESET = 1'b0;
      repeat (3) @(negedge iCLK);
      logCyc.delete();
      expQ.delete();
      iRESET = 1'b1;
   endtask

   task automatic waitStrobes(input int n, input int budget, input string tag);
      int k = 0;
      while (logCyc.size() < n && k < budget) begin
         @(negedge iCLK);
         k++;
      end
      checkOutput(tag, 32'(logCyc.size() >= n), 32'd1);
   endtask

   task automatic waitDrain(input int budget, input string tag);
      int k = 0;
      while ((expQ.size() != 0 || oPKT_BUSY || iTRAN_BUSY) && k < budget) begin
         @(negedge iCLK);
         k++;
      end
      checkOutput(tag, 32'(expQ.size()), 32'd0);
   endtask

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      // Periodic report with reset-state checks.
      iBUTTONS = 16'h1234;
      iAXIS_X  = 8'h80;
      iAXIS_Y  = 8'h7F;
      iENABLE  = 1'b1;
      repeat (3) @(negedge iCLK);
      checkOutput("rstTranSt", {31'd0, oTRAN_ST}, 32'd0);
      checkOutput("rstTxByte", {24'd0, oTX_BYTE}, 32'd0);
      checkOutput("rstPktBusy", {31'd0, oPKT_BUSY}, 32'd0);
      checkOutput("rstPktCnt", {24'd0, oPKT_CNT}, 32'd0);
      checkOutput("rstErrCnt", {24'd0, oERR_CNT}, 32'd0);
      pushReport(16'h1234, 8'h80, 8'h7F);
      iRESET = 1'b1;
      waitDrain(3000, "drainRpt1");
      checkOutput("pktCnt1", {24'd0, oPKT_CNT}, 32'd1);
      pushReport(16'h1234, 8'h80, 8'h7F);
      waitDrain(3000, "drainRpt2");
      checkOutput("period", 32'(logCyc[6] - logCyc[0]), 32'd1000);
      checkOutput("pktCnt2", {24'd0, oPKT_CNT}, 32'd2);

      // Snapshot isolation: inputs change after the first strobe.
      doReset();
      pushReport(16'h1234, 8'h80, 8'h7F);
      waitStrobes(1, 3000, "snapFirst");
      iBUTTONS = 16'hFFFF;
      pushReport(16'hFFFF, 8'h80, 8'h7F);
      waitDrain(3000, "drainSnap");
      iENABLE = 1'b0;
      checkOutput("snapPktCnt", {24'd0, oPKT_CNT}, 32'd2);

      // Ping with periodic reports disabled.
      doReset();
      iBUTTONS = 16'h1234;
      expQ.push_back(8'h5A);
      applyStimulus(1'b0, 8'h02);
      waitDrain(500, "drainPing");
      repeat (50) @(negedge iCLK);
      checkOutput("pingCount", 32'(logCyc.size()), 32'd1);
      checkOutput("pingPktCnt", {24'd0, oPKT_CNT}, 32'd0);

      // Ping and merged report requests arriving mid-report.
      doReset();
      pushReport(16'h1234, 8'h80, 8'h7F);
      applyStimulus(1'b0, 8'h01);
      waitStrobes(1, 500, "arbFirst");
      applyStimulus(1'b0, 8'h02);
      applyStimulus(1'b0, 8'h01);
      applyStimulus(1'b0, 8'h01);
      expQ.push_back(8'h5A);
      pushReport(16'h1234, 8'h80, 8'h7F);
      waitDrain(3000, "drainArb");
      repeat (100) @(negedge iCLK);
      checkOutput("arbCount", 32'(logCyc.size()), 32'd13);
      checkOutput("arbPktCnt", {24'd0, oPKT_CNT}, 32'd2);

      // First strobe ignored by the transmitter.
      doReset();
      dropLeft = 1;
      pushReport(16'h1234, 8'h80, 8'h7F);
      applyStimulus(1'b0, 8'h01);
      waitDrain(3000, "drainRetry");
      checkOutput("retryDropped", {31'd0, 1'(dropLeft == 0)}, 32'd1);
      checkOutput("retryByte", {24'd0, dropByte}, 32'h0000_00A5);
      checkOutput("retryGap", 32'(logCyc[0] - dropCyc), 32'd5);
      checkOutput("retryPktCnt", {24'd0, oPKT_CNT}, 32'd1);

      // Error counting and saturation.
      doReset();
      applyStimulus(1'b0, 8'h33);
      for (int i = 0; i < 3; i++) applyStimulus(1'b1, 8'h00);
      checkOutput("errCnt4", {24'd0, oERR_CNT}, 32'd4);
      checkOutput("errNoTx", 32'(logCyc.size()), 32'd0);
      for (int i = 0; i < 300; i++) applyStimulus(1'b1, 8'h00);
      checkOutput("errSat", {24'd0, oERR_CNT}, 32'd255);

      // Reset mid-packet, then restart from the sync byte on the next tick.
      logCyc.delete();
      expQ.delete();
      pushReport(16'h1234, 8'h80, 8'h7F);
      iENABLE = 1'b1;
      waitStrobes(3, 3000, "abortReach");
      iRESET = 1'b0;
      @(negedge iCLK);
      checkOutput("abortTranSt", {31'd0, oTRAN_ST}, 32'd0);
      checkOutput("abortTxByte", {24'd0, oTX_BYTE}, 32'd0);
      checkOutput("abortPktBusy", {31'd0, oPKT_BUSY}, 32'd0);
      checkOutput("abortPktCnt", {24'd0, oPKT_CNT}, 32'd0);
      checkOutput("abortErrCnt", {24'd0, oERR_CNT}, 32'd0);
      expQ.delete();
      logCyc.delete();
      iRESET = 1'b1;
      pushReport(16'h1234, 8'h80, 8'h7F);
      waitDrain(3000, "drainRestart");
      checkOutput("restartCount", 32'(logCyc.size()), 32'd6);
      checkOutput("restartPktCnt", {24'd0, oPKT_CNT}, 32'd1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
